// File: rtl/puf_pkg.sv
// Shared definitions for the PUF race engine and the downstream overflow
// selection stage.
//   puf_state_t : race FSM state encoding
//   PUF_CNT_W   : default race counter width (also the count1/count2 width
//                 expected by the overflow selection stage)
package puf_pkg;

   typedef enum logic [1:0] {
      PUF_IDLE  = 2'd0,
      PUF_CLEAR = 2'd1,
      PUF_RACE  = 2'd2,
      PUF_HOLD  = 2'd3
   } puf_state_t;

   localparam int PUF_CNT_W = 16;

endpackage

// File: rtl/puf_edge_sync.sv
// Synchronizer plus rising-edge detector for one free-running ring
// oscillator. Runs continuously so a race never starts on a stale edge.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   ro   in  oscillator input, asynchronous to clk
//   rise out one-cycle pulse per synchronized rising edge
module puf_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic ro,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], ro};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/puf_race_counter.sv
// Race engine for one PUF challenge slot. A start pulse clears both
// counters, then synchronized rising edges of ro_a/ro_b are counted until
// either counter wraps. Counts and overflow flags then freeze and valid
// pulses for the overflow selection stage.
// Optional feature macro: PUF_RACE_TIMEOUT_EN adds a race cycle limit and
// the timeout output.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               race request, honoured in IDLE or HOLD
//   ro_a, ro_b          ring oscillators (asynchronous)
//   busy                high in CLEAR and RACE
//   valid               one-cycle pulse on entry to HOLD
//   overflow1/2         counter A/B wrapped, held through HOLD
//   count1/2            counter A/B values
//   timeout             race hit the cycle limit (PUF_RACE_TIMEOUT_EN only)
//
// state     | meaning
// ----------+------------------------------------------------------
// PUF_IDLE  | waiting for start after reset
// PUF_CLEAR | one cycle: zero counts, flags, timeout, cycle counter
// PUF_RACE  | count edges until a counter wraps (or the time limit)
// PUF_HOLD  | results frozen; start launches a new race
module puf_race_counter
   import puf_pkg::*;
#(
   parameter int CNT_W          = PUF_CNT_W,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ro_a,
   input  logic             ro_b,
   output logic             busy,
   output logic             valid,
   output logic             overflow1,
   output logic             overflow2,
`ifdef PUF_RACE_TIMEOUT_EN
   output logic             timeout,
`endif
   output logic [CNT_W-1:0] count1,
   output logic [CNT_W-1:0] count2
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   puf_state_t       state, state_nxt;
   logic [CNT_W-1:0] count1_nxt, count2_nxt;
   logic             overflow1_nxt, overflow2_nxt, valid_nxt;
   logic             rise_a, rise_b, wrap_a, wrap_b;

   puf_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
      .clk  (clk),
      .rst  (rst),
      .ro   (ro_a),
      .rise (rise_a)
   );

   puf_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
      .clk  (clk),
      .rst  (rst),
      .ro   (ro_b),
      .rise (rise_b)
   );

   assign wrap_a = rise_a & (count1 == '1);
   assign wrap_b = rise_b & (count2 == '1);
   assign busy   = (state == PUF_CLEAR) || (state == PUF_RACE);

`ifdef PUF_RACE_TIMEOUT_EN
   localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

   logic [TMO_W-1:0] tcnt, tcnt_nxt;
   logic             timeout_nxt;
`endif

   always_comb begin
      state_nxt     = state;
      count1_nxt    = count1;
      count2_nxt    = count2;
      overflow1_nxt = overflow1;
      overflow2_nxt = overflow2;
      valid_nxt     = 1'b0;
`ifdef PUF_RACE_TIMEOUT_EN
      tcnt_nxt      = tcnt;
      timeout_nxt   = timeout;
`endif
      case (state)
         PUF_IDLE, PUF_HOLD: begin
            if (start) state_nxt = PUF_CLEAR;
         end
         PUF_CLEAR: begin
            count1_nxt    = '0;
            count2_nxt    = '0;
            overflow1_nxt = 1'b0;
            overflow2_nxt = 1'b0;
`ifdef PUF_RACE_TIMEOUT_EN
            tcnt_nxt      = '0;
            timeout_nxt   = 1'b0;
`endif
            state_nxt     = PUF_RACE;
         end
         PUF_RACE: begin
            // The losing counter still takes its same-cycle edge.
            if (rise_a) count1_nxt = count1 + CNT_ONE;
            if (rise_b) count2_nxt = count2 + CNT_ONE;
`ifdef PUF_RACE_TIMEOUT_EN
            tcnt_nxt = tcnt + TMO_ONE;
`endif
            if (wrap_a || wrap_b) begin
               overflow1_nxt = wrap_a;
               overflow2_nxt = wrap_b;
               valid_nxt     = 1'b1;
               state_nxt     = PUF_HOLD;
            end
`ifdef PUF_RACE_TIMEOUT_EN
            // Overflow wins over the time limit in the same cycle.
            else if (tcnt == TMO_LAST) begin
               timeout_nxt = 1'b1;
               valid_nxt   = 1'b1;
               state_nxt   = PUF_HOLD;
            end
`endif
         end
         default: state_nxt = PUF_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= PUF_IDLE;
         count1    <= '0;
         count2    <= '0;
         overflow1 <= 1'b0;
         overflow2 <= 1'b0;
         valid     <= 1'b0;
      end else begin
         state     <= state_nxt;
         count1    <= count1_nxt;
         count2    <= count2_nxt;
         overflow1 <= overflow1_nxt;
         overflow2 <= overflow2_nxt;
         valid     <= valid_nxt;
      end
   end

`ifdef PUF_RACE_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt    <= '0;
         timeout <= 1'b0;
      end else begin
         tcnt    <= tcnt_nxt;
         timeout <= timeout_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_puf_race_counter.sv
module tb_puf_race_counter;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          ro_a = 1'b0;
   logic          ro_b = 1'b0;
   logic          busy, valid, overflow1, overflow2;
   logic [CW-1:0] count1, count2;
`ifdef PUF_RACE_TIMEOUT_EN
   logic          timeout;
`endif

   int checks = 0;
   int errors = 0;
   int vcount = 0;

   puf_race_counter #(
      .CNT_W          (CW),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ro_a      (ro_a),
      .ro_b      (ro_b),
      .busy      (busy),
      .valid     (valid),
      .overflow1 (overflow1),
      .overflow2 (overflow2),
`ifdef PUF_RACE_TIMEOUT_EN
      .timeout   (timeout),
`endif
      .count1    (count1),
      .count2    (count2)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (valid === 1'b1) vcount++;

   // na edges on A and nb edges on B, one edge per two cycles, aligned.
   task automatic ro_edges(input int na, input int nb);
      int n;
      n = (na > nb) ? na : nb;
      for (int i = 0; i < n; i++) begin
         ro_a = (i < na);
         ro_b = (i < nb);
         @(negedge clk);
         ro_a = 1'b0;
         ro_b = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (valid !== 1'b1) begin
         errors++;
         $display("FAIL %s wait_valid: valid=%b after %0d cycles, required 1", name, valid, n);
      end
   endtask

   task automatic test_reset();
      int v0;
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         ro_a = ~ro_a;
         ro_b = ~ro_b;
      end
      checks++; if ({busy, valid, overflow1, overflow2, count1, count2} !== '0) begin
         errors++; $display("FAIL reset outputs: got %b required 0", {busy, valid, overflow1, overflow2, count1, count2}); end
      ro_a = 1'b0; ro_b = 1'b0;
      rst = 1'b0;
      v0 = vcount;
      ro_edges(5, 5);
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b required 0", busy); end
      checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL idle count1: got %0d required 0", count1); end
      checks++; if (count2 !== 4'd0) begin errors++; $display("FAIL idle count2: got %0d required 0", count2); end
      checks++; if (vcount != v0) begin errors++; $display("FAIL idle valid_pulses: got %0d required 0", vcount - v0); end
   endtask

   task automatic test_a_wins();
      int v0;
      v0 = vcount;
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a_wins busy_clear: got %b required 1", busy); end
      @(negedge clk);
      ro_edges(16, 9);
      wait_valid("a_wins");
      checks++; if (overflow1 !== 1'b1) begin errors++; $display("FAIL a_wins overflow1: got %b required 1", overflow1); end
      checks++; if (overflow2 !== 1'b0) begin errors++; $display("FAIL a_wins overflow2: got %b required 0", overflow2); end
      checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL a_wins count1: got %0d required 0", count1); end
      checks++; if (count2 !== 4'd9) begin errors++; $display("FAIL a_wins count2: got %0d required 9", count2); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a_wins busy: got %b required 0", busy); end
      @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL a_wins valid_width: got %b required 0", valid); end
      checks++; if (vcount - v0 != 1) begin errors++; $display("FAIL a_wins valid_pulses: got %0d required 1", vcount - v0); end
      checks++; if (count2 !== 4'd9) begin errors++; $display("FAIL a_wins hold_count2: got %0d required 9", count2); end
   endtask

   task automatic test_start_handling();
      int v0;
      v0 = vcount;
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart busy: got %b required 1", busy); end
      @(negedge clk);
      checks++; if (count2 !== 4'd0) begin errors++; $display("FAIL restart count2: got %0d required 0", count2); end
      checks++; if (overflow1 !== 1'b0) begin errors++; $display("FAIL restart overflow1: got %b required 0", overflow1); end
      ro_edges(3, 8);
      repeat (4) @(negedge clk);
      checks++; if (count1 !== 4'd3) begin errors++; $display("FAIL race count1: got %0d required 3", count1); end
      checks++; if (count2 !== 4'd8) begin errors++; $display("FAIL race count2: got %0d required 8", count2); end
      pulse_start();
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_in_race busy: got %b required 1", busy); end
      checks++; if (count1 !== 4'd3) begin errors++; $display("FAIL start_in_race count1: got %0d required 3", count1); end
      ro_edges(2, 8);
      wait_valid("b_wins");
      checks++; if (overflow1 !== 1'b0) begin errors++; $display("FAIL b_wins overflow1: got %b required 0", overflow1); end
      checks++; if (overflow2 !== 1'b1) begin errors++; $display("FAIL b_wins overflow2: got %b required 1", overflow2); end
      checks++; if (count1 !== 4'd5) begin errors++; $display("FAIL b_wins count1: got %0d required 5", count1); end
      checks++; if (count2 !== 4'd0) begin errors++; $display("FAIL b_wins count2: got %0d required 0", count2); end
      @(negedge clk);
      checks++; if (vcount - v0 != 1) begin errors++; $display("FAIL b_wins valid_pulses: got %0d required 1", vcount - v0); end
   endtask

   task automatic test_tie();
      int v0;
      v0 = vcount;
      pulse_start();
      @(negedge clk);
      ro_edges(15, 15);
      repeat (4) @(negedge clk);
      checks++; if (count1 !== 4'd15) begin errors++; $display("FAIL tie pre_count1: got %0d required 15", count1); end
      checks++; if (count2 !== 4'd15) begin errors++; $display("FAIL tie pre_count2: got %0d required 15", count2); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tie pre_busy: got %b required 1", busy); end
      checks++; if (overflow1 !== 1'b0) begin errors++; $display("FAIL tie pre_overflow1: got %b required 0", overflow1); end
      ro_edges(1, 1);
      wait_valid("tie");
      checks++; if (overflow1 !== 1'b1) begin errors++; $display("FAIL tie overflow1: got %b required 1", overflow1); end
      checks++; if (overflow2 !== 1'b1) begin errors++; $display("FAIL tie overflow2: got %b required 1", overflow2); end
      checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL tie count1: got %0d required 0", count1); end
      checks++; if (count2 !== 4'd0) begin errors++; $display("FAIL tie count2: got %0d required 0", count2); end
      @(negedge clk);
      checks++; if (vcount - v0 != 1) begin errors++; $display("FAIL tie valid_pulses: got %0d required 1", vcount - v0); end
   endtask

   task automatic test_reset_mid_race();
      int v0;
      pulse_start();
      @(negedge clk);
      ro_edges(7, 3);
      repeat (4) @(negedge clk);
      checks++; if (count1 !== 4'd7) begin errors++; $display("FAIL midrst pre_count1: got %0d required 7", count1); end
      v0 = vcount;
      ro_a = 1'b1;
      #2 rst = 1'b1;
      #1;
      checks++; if ({busy, valid, overflow1, overflow2, count1, count2} !== '0) begin
         errors++; $display("FAIL midrst async_outputs: got %b required 0", {busy, valid, overflow1, overflow2, count1, count2}); end
      repeat (3) begin
         @(negedge clk);
         ro_a = ~ro_a;
         ro_b = ~ro_b;
      end
      rst = 1'b0;
      ro_a = 1'b0; ro_b = 1'b0;
      repeat (6) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst busy_after: got %b required 0", busy); end
      checks++; if (count1 !== 4'd0) begin errors++; $display("FAIL midrst count1_after: got %0d required 0", count1); end
      checks++; if (vcount != v0) begin errors++; $display("FAIL midrst valid_pulses: got %0d required 0", vcount - v0); end
   endtask

`ifdef PUF_RACE_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      pulse_start();
      @(negedge clk);
      n = 0;
      while (valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n != 100) begin errors++; $display("FAIL timeout latency: got %0d required 100", n); end
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout flag: got %b required 1", timeout); end
      checks++; if ({overflow1, overflow2} !== 2'b00) begin errors++; $display("FAIL timeout overflows: got %b required 00", {overflow1, overflow2}); end
   endtask
`endif

   initial begin
      test_reset();
      repeat (3) @(negedge clk);
      test_a_wins();
      test_start_handling();
      test_tie();
      test_reset_mid_race();
`ifdef PUF_RACE_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/puf_race_counter.md
# puf_race_counter

Race engine that drives the PUF overflow/count interface. On a start pulse it clears two counters, then counts synchronized rising edges from two free-running ring-oscillator inputs until either counter overflows. It then freezes both counts and the overflow flags and pulses `valid`, so the downstream overflow-selection logic can extract response bits. It sits between the ring-oscillator pair and the overflow selection stage, one instance per challenge slot.

## Interface
- `CNT_W`, 16, counter width; matches the downstream `count1`/`count2` width.
- `SYNC_STAGES`, 2, flip-flop stages in each oscillator synchronizer (minimum 2).
- `TIMEOUT_CYCLES`, 1048576, race cycle limit; used only with `PUF_RACE_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to run a race; honoured only in IDLE or HOLD.
- `ro_a`  in  1  ring-oscillator A; asynchronous to `clk`.
- `ro_b`  in  1  ring-oscillator B; asynchronous to `clk`.
- `busy`  out  1  high in CLEAR and RACE.
- `valid`  out  1  one-cycle pulse on entry to HOLD.
- `overflow1`  out  1  counter A overflowed; held through HOLD.
- `overflow2`  out  1  counter B overflowed; held through HOLD.
- `count1`  out  CNT_W  counter A value.
- `count2`  out  CNT_W  counter B value.
- `timeout`  out  1  race ended without overflow; port exists only with `PUF_RACE_TIMEOUT_EN`.

## Operation
- Each oscillator path: SYNC_STAGES synchronizer, then one previous-value register. Rising edge = `sync & ~prev`. Synchronizers run continuously, including in IDLE, so a race never sees a stale edge at its first cycle.
- FSM states: IDLE, CLEAR, RACE, HOLD.
- IDLE: `start` moves to CLEAR.
- CLEAR: lasts one cycle. Zeroes counts, flags and `timeout`, then moves to RACE.
- RACE: each detected edge increments its counter by 1, modulo 2^CNT_W.
  - An edge arriving at count all-ones wraps that counter to 0 and sets its overflow flag.
  - Any flag set moves the FSM to HOLD, with `valid` high in the first HOLD cycle.
- Simultaneous overflow in the same cycle: both flags are set and both counters read 0.
- A single-flag overflow: the losing counter includes any edge detected in the same cycle.
- HOLD: counts and flags frozen; edges are ignored. `start` moves to CLEAR.
- `start` during CLEAR or RACE is ignored, not queued.
- Reset asserted at any time: FSM goes to IDLE; all outputs, counters, synchronizers and edge registers go to 0. No `valid` is produced for the aborted race.
- Reset values: `busy`=0, `valid`=0, `overflow1`=0, `overflow2`=0, `count1`=0, `count2`=0, `timeout`=0.

## Timing
- `ro_x` rising edge to count increment: SYNC_STAGES+1 cycles; the count is visible one cycle after that.
- `start` to `busy` high: 1 cycle (CLEAR). RACE begins 2 cycles after `start`.
- Overflow edge detected to flags, counts and `valid`: the same registered update, 1 cycle after detection.
- `busy` falls in the same cycle `valid` rises.
- Maximum countable oscillator rate: clk/2, i.e. one edge per two cycles. Faster inputs alias; this is a system constraint, not checked by the block.

## Configuration
- `PUF_RACE_TIMEOUT_EN` defined: adds a cycle counter cleared in CLEAR and incremented each RACE cycle. When it reaches TIMEOUT_CYCLES with no overflow, the FSM moves to HOLD:
  - `timeout`=1, both flags 0, counts frozen, `valid` pulses.
  - An overflow in the same cycle takes priority and leaves `timeout`=0.
- Macro undefined: no timeout counter and no `timeout` port. A dead oscillator pair keeps the block in RACE until `rst`.

## Structure
- Shared package `puf_pkg` holds:
  - the state enum (`PUF_IDLE`, `PUF_CLEAR`, `PUF_RACE`, `PUF_HOLD`);
  - the default counter width constant (16), shared with the overflow selection stage.
- Sub-module `puf_edge_sync`: synchronizer plus rising-edge detector, parameterised by SYNC_STAGES, instantiated once per oscillator.
- FSM, counters and optional timeout counter live in the top module.

## Test plan
- Reset and idle: assert `rst` mid-simulation with oscillators toggling -> all outputs 0; after release, `busy`=0 and the counts stay 0 while no `start` is given.
- A wins: CNT_W=4; after `start`, 16 A edges and 9 B edges -> `overflow1`=1, `overflow2`=0, `count1`=0, `count2`=9, `valid` high exactly 1 cycle, `busy`=0.
- Tie: CNT_W=4; drive both counters to 15, then place the final edges on both in the same cycle -> `overflow1`=`overflow2`=1, both counts 0, single `valid` pulse.
- Start handling: pulse `start` during RACE -> no effect and no extra `valid`. Pulse `start` in HOLD -> flags and counts are 0 on the cycle after CLEAR, and a second race completes normally.
- Reset mid-race: assert `rst` while `count1`=7 -> all outputs 0 immediately (asynchronous), FSM in IDLE, no `valid`.
- Timeout (macro defined): TIMEOUT_CYCLES=100, both oscillators held static -> `timeout`=1 and `valid` pulse 100 cycles after RACE entry, both flags 0.
